bist_controller: RTL and testbench

- Sequencing and response-analysis stage for the 4-bit adder BIST chain.
- Clears the pattern generator and signature register, then enables them for exactly TEST_CYCLES cycles.
- Captures the final 5-bit MISR signature and compares it against a golden constant.
- Reports busy/done/pass/fail. Sits downstream of the MISR (consumes its signature) and drives the shared enable/clear of the LFSR and MISR.

---
 rtl/bist_controller.sv | 104 ++++++++++
 tb/tb_bist_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// BIST sequencer: clears the TPG/MISR, enables them for TEST_CYCLES cycles,
// then captures the MISR signature and grades it against GOLDEN.
module bist_controller #(
    parameter int unsigned       SIG_W       = 5,
    parameter int unsigned       CNT_W       = 16,
    parameter int unsigned       TEST_CYCLES = 64,
    parameter logic [SIG_W-1:0]  GOLDEN      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] sig_in,
    output logic             tpg_clear,
    output logic             tpg_enable,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [SIG_W-1:0] sig_captured,
    output logic [CNT_W-1:0] pattern_count
);

    if (TEST_CYCLES == 0 || 64'(TEST_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cycles
        $error("bist_controller: TEST_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TEST_CYCLES);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt_next, cnt_inc;
    logic [SIG_W-1:0] cap_next;
    logic             pass_next, fail_next;
    logic             clr_next, en_next, busy_next, done_next;

    assign cnt_inc = pattern_count + CNT_W'(1);

    always_comb begin
        state_next = state;
        cnt_next   = pattern_count;
        cap_next   = sig_captured;
        pass_next  = pass;
        fail_next  = fail;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: state_next = RUN;
            RUN: begin
                cnt_next = cnt_inc;
                if (cnt_inc == LAST) state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = DONE;
                cap_next   = sig_in;
                pass_next  = (sig_in == GOLDEN);
                fail_next  = (sig_in != GOLDEN);
            end
            DONE: begin
                if (start) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                    pass_next  = 1'b0;
                    fail_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        // Outputs are registered from the next state so they align with it
        clr_next  = (state_next == CLEAR);
        en_next   = (state_next == RUN);
        busy_next = (state_next == CLEAR) || (state_next == RUN) || (state_next == CAPTURE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            pattern_count <= '0;
            sig_captured  <= '0;
            tpg_clear     <= 1'b1;
            tpg_enable    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_next;
            pattern_count <= cnt_next;
            sig_captured  <= cap_next;
            tpg_clear     <= clr_next;
            tpg_enable    <= en_next;
            busy          <= busy_next;
            done          <= done_next;
            pass          <= pass_next;
            fail          <= fail_next;
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller with TEST_CYCLES=4, GOLDEN=5'h15 and a stubbed
// signature input: cycle vectors plus scoreboarded whole-run checks.
module tb_bist_controller;

    localparam int unsigned TC   = 4;
    localparam logic [4:0]  GOLD = 5'h15;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [4:0]  sig_in;
    logic        tpg_clear, tpg_enable, busy, done, pass, fail;
    logic [4:0]  sig_captured;
    logic [15:0] pattern_count;

    bist_controller #(
        .SIG_W(5), .CNT_W(16), .TEST_CYCLES(TC), .GOLDEN(GOLD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
        .tpg_clear(tpg_clear), .tpg_enable(tpg_enable), .busy(busy),
        .done(done), .pass(pass), .fail(fail),
        .sig_captured(sig_captured), .pattern_count(pattern_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic [4:0]  sig;
        logic [26:0] exp;   // {clr,en,busy,done,pass,fail,cap[4:0],cnt[15:0]}
    } vec_t;

    typedef struct {
        logic       pass;
        logic       fail;
        logic [4:0] cap;
    } verdict_t;

    vec_t     vecs[$];
    vec_t     sb_vec[$];
    verdict_t sb_run[$];
    int       total = 0;
    int       bad   = 0;

    function automatic vec_t mkv(input logic r, input logic s, input logic [4:0] sg,
                                 input logic c, input logic e, input logic b, input logic d,
                                 input logic p, input logic f, input logic [4:0] cap,
                                 input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.start = s; v.sig = sg;
        v.exp = {c, e, b, d, p, f, cap, cnt};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        vec_t e;
        @(negedge clk);
        rst = v.rst; start = v.start; sig_in = v.sig;
        sb_vec.push_back(v);
        @(posedge clk); #1;
        e = sb_vec.pop_front();
        chk(name, 32'({tpg_clear, tpg_enable, busy, done, pass, fail, sig_captured, pattern_count}),
            32'(e.exp));
    endtask

    // One full run from IDLE/DONE; optionally re-pulses start mid-RUN
    task automatic run_check(input logic [4:0] s, input bit poke, input string name);
        verdict_t e;
        int n, en_cnt, clr_cnt;
        bit seen;
        e.pass = (s == GOLD); e.fail = (s != GOLD); e.cap = s;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; sig_in = s;
        sb_run.push_back(e);
        @(posedge clk); #1;
        chk({name, " clear"}, 32'(tpg_clear), 32'd1);
        n = 0; en_cnt = 0; clr_cnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            start = poke && (pattern_count == 16'd2);
            @(posedge clk); #1;
            n++;
            if (tpg_enable) en_cnt++;
            if (tpg_clear) clr_cnt++;
            if (done) seen = 1;
        end
        start = 1'b0;
        e = sb_run.pop_front();
        chk({name, " done seen"}, 32'(seen), 32'd1);
        chk({name, " latency"}, 32'(n), TC + 2);
        chk({name, " enables"}, 32'(en_cnt), TC);
        chk({name, " extra clears"}, 32'(clr_cnt), 32'd0);
        chk({name, " pass"}, 32'(pass), 32'(e.pass));
        chk({name, " fail"}, 32'(fail), 32'(e.fail));
        chk({name, " sig"}, 32'(sig_captured), 32'(e.cap));
        chk({name, " count"}, 32'(pattern_count), TC);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b1; sig_in = 5'h15;

        // reset hold, idle, pass run, fail run
        for (int i = 0; i < 3; i++) vecs.push_back(mkv(0, 1, 5'h15, 1, 0, 0, 0, 0, 0, 5'h00, 0));
        vecs.push_back(mkv(1, 0, 5'h15, 0, 0, 0, 0, 0, 0, 5'h00, 0));
        vecs.push_back(mkv(1, 0, 5'h15, 0, 0, 0, 0, 0, 0, 5'h00, 0));
        vecs.push_back(mkv(1, 1, 5'h15, 1, 0, 1, 0, 0, 0, 5'h00, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(1, 0, 5'h15, 0, 1, 1, 0, 0, 0, 5'h00, 16'(i)));
        vecs.push_back(mkv(1, 0, 5'h15, 0, 0, 1, 0, 0, 0, 5'h00, 4));
        vecs.push_back(mkv(1, 0, 5'h15, 0, 0, 0, 1, 1, 0, 5'h15, 4));
        vecs.push_back(mkv(1, 0, 5'h15, 0, 0, 0, 1, 1, 0, 5'h15, 4));
        vecs.push_back(mkv(1, 1, 5'h14, 1, 0, 1, 0, 0, 0, 5'h15, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(1, 0, 5'h14, 0, 1, 1, 0, 0, 0, 5'h15, 16'(i)));
        vecs.push_back(mkv(1, 0, 5'h14, 0, 0, 1, 0, 0, 0, 5'h15, 4));
        vecs.push_back(mkv(1, 0, 5'h14, 0, 0, 0, 1, 0, 1, 5'h14, 4));
        vecs.push_back(mkv(1, 0, 5'h14, 0, 0, 0, 1, 0, 1, 5'h14, 4));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        run_check(5'h15, 1'b1, "start during run");
        run_check(5'h15, 1'b0, "rerun");
        run_check(5'h14, 1'b0, "fail rerun");

        // reset while pattern_count==3
        apply(mkv(1, 1, 5'h15, 1, 0, 1, 0, 0, 0, 5'h14, 0), "mid clear");
        for (int i = 0; i < 4; i++)
            apply(mkv(1, 0, 5'h15, 0, 1, 1, 0, 0, 0, 5'h14, 16'(i)), $sformatf("mid run%0d", i));
        apply(mkv(0, 0, 5'h15, 1, 0, 0, 0, 0, 0, 5'h00, 0), "mid reset");
        apply(mkv(1, 0, 5'h15, 0, 0, 0, 0, 0, 0, 5'h00, 0), "idle after reset");
        run_check(5'h15, 1'b0, "after reset");

        // start held: DONE lasts one cycle with a valid verdict, then re-clears
        apply(mkv(1, 1, 5'h14, 1, 0, 1, 0, 0, 0, 5'h15, 0), "held clear");
        for (int i = 0; i < 4; i++)
            apply(mkv(1, 1, 5'h14, 0, 1, 1, 0, 0, 0, 5'h15, 16'(i)), $sformatf("held run%0d", i));
        apply(mkv(1, 1, 5'h14, 0, 0, 1, 0, 0, 0, 5'h15, 4), "held capture");
        apply(mkv(1, 1, 5'h14, 0, 0, 0, 1, 0, 1, 5'h14, 4), "held done");
        apply(mkv(1, 1, 5'h14, 1, 0, 1, 0, 0, 0, 5'h14, 0), "held reclear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
